// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control stage.
// Holds the 3-bit op encoding seen on req_op/alu_sel/rsp_op and the
// sequencer state enum used by alu_sequencer.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_LT  = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MOD = 3'b111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EXEC  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/alu_sequencer.sv
// Purpose: control stage in front of the 32-bit ALU; registers one request, drives the ALU, captures the result.
// Latency: single-cycle ops respond 2 edges after accept; MOD after done (counter>=1) or MOD_TIMEOUT+2 edges on timeout.
// Backpressure: req_ready only in IDLE; response held in RESP until rsp_ready, one op in flight at a time.
//
// Ports:
//   clk, reset                         clock and synchronous active-high reset
//   req_valid/req_ready, req_op/a/b/cin   request handshake and payload
//   alu_a/b/sel/cin                    registered ALU inputs, held from accept to next accept
//   alu_start, alu_reset               MOD start pulse; ALU reset (reset or one-cycle timeout abort)
//   alu_result, alu_cout, alu_done     ALU outputs
//   rsp_valid/rsp_ready, rsp_result/cout/err/op   held response channel
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int MOD_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        req_cin,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_sel,
  output logic        alu_cin,
  output logic        alu_start,
  output logic        alu_reset,
  input  logic [31:0] alu_result,
  input  logic        alu_cout,
  input  logic        alu_done,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_cout,
  output logic        rsp_err,
  output logic [2:0]  rsp_op
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MOD_TIMEOUT - 1);

  seq_state_t       state_q;
  seq_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             abort_q;
  logic             done_take;
  logic             timeout_hit;

  // A done seen while the counter is still 0 may be left over from a
  // previous MOD, so it is only honoured from the second WAIT cycle on.
  // Done has priority over the timeout when both land in the same cycle.
  assign done_take   = alu_done && (cnt_q != '0);
  assign timeout_hit = !done_take && (cnt_q == CNT_MAX);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = (req_op == OP_MOD) ? START : EXEC;
      EXEC:    state_d = RESP;
      START:   state_d = WAIT;
      WAIT:    if (done_take || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; gated by reset so they read as idle
  // during the reset cycle regardless of the state register contents.
  always_comb begin
    req_ready = 1'b0;
    alu_start = 1'b0;
    rsp_valid = 1'b0;
    alu_reset = reset | abort_q;
    if (!reset) begin
      req_ready = (state_q == IDLE);
      alu_start = (state_q == START);
      rsp_valid = (state_q == RESP);
    end
  end

  // Operand, counter and response registers. alu_sel doubles as the
  // stored op, so rsp_op is taken from it at capture time.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      alu_cin    <= 1'b0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_op     <= '0;
      cnt_q      <= '0;
      abort_q    <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            alu_a   <= req_a;
            alu_b   <= req_b;
            alu_sel <= req_op;
            alu_cin <= req_cin;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_cout   <= alu_cout;
          rsp_err    <= 1'b0;
          rsp_op     <= alu_sel;
        end
        START: begin
          cnt_q <= '0;
        end
        WAIT: begin
          if (done_take) begin
            rsp_result <= alu_result;
            rsp_cout   <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_op     <= alu_sel;
          end else if (timeout_hit) begin
            // Abort the MOD unit for one cycle and report an error.
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
            rsp_err    <= 1'b1;
            rsp_op     <= alu_sel;
            abort_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
